// File: rtl/rv_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one synchronous imem read
// per cycle and buffers returned words with their PCs in a small prefetch queue.
module rv_fetch_unit #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [31:0]       imem_instr_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              instr_valid_o,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    input  logic              instr_ready_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        RUN,
        REDIR
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              squash;

    logic [31:0]       instr_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic              pop;
    logic              push;
    logic              issue;
    logic [CNT_W:0]    occupancy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     state_nxt = redirect_i ? REDIR : RUN;
            REDIR:   state_nxt = redirect_i ? REDIR : RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Occupancy counts the in-flight word as already queued so the queue
    // can never be oversubscribed; a pop this cycle frees a slot immediately.
    always_comb begin
        occupancy = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
        issue     = !rst && !redirect_i && (occupancy < (CNT_W+1)'(DEPTH));
        push      = inflight && !((state == REDIR) && squash);
    end

    assign instr_valid_o = !rst && (count != '0);
    assign pop           = instr_valid_o && instr_ready_i;
    assign imem_req_o    = issue;
    assign imem_addr_o   = fetch_pc;
    assign instr_o       = rst ? '0 : instr_mem[head];
    assign instr_pc_o    = rst ? '0 : pc_mem[head];

    // Redirect outranks push, pop and issue: the queue is flushed and any
    // response landing in the following cycle is dropped via squash.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= '0;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            squash      <= 1'b0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (redirect_i) begin
            fetch_pc <= redirect_pc_i;
            squash   <= inflight;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            squash <= 1'b0;
            if (push) begin
                instr_mem[tail] <= imem_instr_i;
                pc_mem[tail]    <= inflight_pc;
                tail            <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count    <= count + CNT_W'(push) - CNT_W'(pop);
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Bench for rv_fetch_unit: hand-derived vector table, directed corner cases,
// and random traffic checked against a queue-level reference model.
module tb_rv_fetch_unit;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              imem_req_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [31:0]       imem_instr_i = '0;
    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic              instr_valid_o;
    logic [31:0]       instr_o;
    logic [ADDR_W-1:0] instr_pc_o;
    logic              instr_ready_i;

    int checks = 0;
    int errors = 0;

    rv_fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_instr_i  (imem_instr_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [ADDR_W-1:0] a);
        return 32'h1000_0000 + 32'(a);
    endfunction

    // Memory answers one cycle after a request; junk otherwise.
    always @(posedge clk) begin
        imem_instr_i <= imem_req_o ? memWord(imem_addr_o) : $urandom;
    end

    // Reference model: queue of delivered PCs plus one pending request.
    logic [ADDR_W-1:0] mq[$];
    logic              mPend;
    logic [ADDR_W-1:0] mPendPc;
    logic [ADDR_W-1:0] mFpc;
    logic              mSquash;

    logic              obsValid, obsReq;
    logic [ADDR_W-1:0] obsPc, obsAddr;
    logic [31:0]       obsInstr;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rd, input logic [ADDR_W-1:0] rpc,
                                 input logic rdy);
        logic eValid, ePop, eReq;
        rst           = r;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        instr_ready_i = rdy;
        #1;
        obsValid = instr_valid_o;
        obsPc    = instr_pc_o;
        obsInstr = instr_o;
        obsReq   = imem_req_o;
        obsAddr  = imem_addr_o;
        eValid = !r && (mq.size() != 0);
        ePop   = eValid && rdy;
        eReq   = !r && !rd && ((int'(mq.size()) - int'(ePop) + int'(mPend)) < DEPTH);
        checkOutput("model_valid", 32'(obsValid), 32'(eValid));
        if (eValid) begin
            checkOutput("model_pc", 32'(obsPc), 32'(mq[0]));
            checkOutput("model_instr", obsInstr, memWord(mq[0]));
        end
        if (r) begin
            checkOutput("model_rst_instr", obsInstr, 32'h0);
            checkOutput("model_rst_pc", 32'(obsPc), 32'h0);
        end
        checkOutput("model_req", 32'(obsReq), 32'(eReq));
        if (eReq) checkOutput("model_addr", 32'(obsAddr), 32'(mFpc));
        @(posedge clk);
        if (r) begin
            mq.delete();
            mPend = 1'b0; mFpc = '0; mSquash = 1'b0;
        end else if (rd) begin
            mq.delete();
            mSquash = mPend; mPend = 1'b0; mFpc = rpc;
        end else begin
            if (ePop) void'(mq.pop_front());
            if (mPend && !mSquash) mq.push_back(mPendPc);
            mSquash = 1'b0;
            if (eReq) begin
                mPend = 1'b1; mPendPc = mFpc; mFpc = mFpc + 1'b1;
            end else begin
                mPend = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic expectHead(input string name, input logic v, input logic [ADDR_W-1:0] pc);
        checkOutput({name, "_valid"}, 32'(obsValid), 32'(v));
        if (v) begin
            checkOutput({name, "_pc"}, 32'(obsPc), 32'(pc));
            checkOutput({name, "_instr"}, obsInstr, memWord(pc));
        end
    endtask

    task automatic expectReq(input string name, input logic q, input logic [ADDR_W-1:0] a);
        checkOutput({name, "_req"}, 32'(obsReq), 32'(q));
        if (q) checkOutput({name, "_addr"}, 32'(obsAddr), 32'(a));
    endtask

    typedef struct {
        logic              r;
        logic              rdy;
        logic              v;
        logic [ADDR_W-1:0] pc;
        logic              q;
        logic [ADDR_W-1:0] a;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic rdy, input logic v, input int pc,
                                input logic q, input int a);
        vec_t t;
        t.r = r; t.rdy = rdy; t.v = v; t.pc = ADDR_W'(pc); t.q = q; t.a = ADDR_W'(a);
        return t;
    endfunction

    initial begin
        mq.delete();
        mPend = 1'b0; mPendPc = '0; mFpc = '0; mSquash = 1'b0;
        rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; instr_ready_i = 1'b0;
        @(negedge clk);

        // Startup with ready high, then refill with ready low until full.
        vecs.push_back(mk(1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 0, 1, 2));
        vecs.push_back(mk(0, 1, 1, 1, 1, 3));
        vecs.push_back(mk(0, 1, 1, 2, 1, 4));
        vecs.push_back(mk(0, 1, 1, 3, 1, 5));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 2));
        vecs.push_back(mk(0, 0, 1, 0, 1, 3));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 4));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0));
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].r, 1'b0, '0, vecs[i].rdy);
            expectHead($sformatf("vec%0d", i), vecs[i].v, vecs[i].pc);
            expectReq($sformatf("vec%0d", i), vecs[i].q, vecs[i].a);
        end

        // Redirect while queue holds 5,6 and word 7 is in flight.
        applyStimulus(1, 0, '0, 1);
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, '0, 1);
        applyStimulus(0, 0, '0, 0);
        expectHead("pre_redir", 1, 10'd5);
        expectReq("pre_redir", 1, 10'd7);
        applyStimulus(0, 1, 10'h155, 0);
        expectReq("redir_cycle", 0, 10'd0);
        applyStimulus(0, 0, '0, 1);
        expectHead("redir_p1", 0, 10'd0);
        expectReq("redir_p1", 1, 10'h155);
        applyStimulus(0, 0, '0, 1);
        expectHead("redir_p2", 0, 10'd0);
        applyStimulus(0, 0, '0, 1);
        expectHead("redir_p3", 1, 10'h155);
        applyStimulus(0, 0, '0, 1);
        expectHead("redir_p4", 1, 10'h156);

        // PC wrap across the top of the address space.
        applyStimulus(0, 1, 10'h3FE, 1);
        applyStimulus(0, 0, '0, 1);
        expectReq("wrap_p1", 1, 10'h3FE);
        applyStimulus(0, 0, '0, 1);
        expectReq("wrap_p2", 1, 10'h3FF);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, '0, 1);
            expectHead($sformatf("wrap_d%0d", i), 1, ADDR_W'(10'h3FE + i));
        end

        // Redirect together with a pop while the queue is full.
        applyStimulus(1, 0, '0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, '0, 0);
        expectReq("full_hold", 0, 10'd0);
        applyStimulus(0, 1, 10'h020, 1);
        expectHead("full_redir", 1, 10'd0);
        applyStimulus(0, 0, '0, 1);
        expectHead("full_p1", 0, 10'd0);
        expectReq("full_p1", 1, 10'h020);
        applyStimulus(0, 0, '0, 1);
        expectHead("full_p2", 0, 10'd0);
        applyStimulus(0, 0, '0, 1);
        expectHead("full_p3", 1, 10'h020);
        applyStimulus(0, 0, '0, 1);
        expectHead("full_p4", 1, 10'h021);

        // One-cycle reset mid-stream with three entries queued.
        applyStimulus(1, 0, '0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, '0, 0);
        applyStimulus(1, 0, '0, 1);
        expectReq("mrst", 0, 10'd0);
        checkOutput("mrst_valid", 32'(obsValid), 32'h0);
        checkOutput("mrst_instr", obsInstr, 32'h0);
        applyStimulus(0, 0, '0, 1);
        checkOutput("mrst_p0_valid", 32'(obsValid), 32'h0);
        checkOutput("mrst_p0_instr", obsInstr, 32'h0);
        expectReq("mrst_p0", 1, 10'd0);
        applyStimulus(0, 0, '0, 1);
        expectHead("mrst_p1", 0, 10'd0);
        applyStimulus(0, 0, '0, 1);
        expectHead("mrst_p2", 1, 10'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 99) == 0),
                          ($urandom_range(0, 15) == 0),
                          ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1)),
                          ($urandom_range(0, 9) < 7));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
